// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 command transmitter.
// Sends one byte on open-drain PS2_CLK/PS2_DAT and reports ack or timeout.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int TX_TIMEOUT     = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);
    localparam int PW = $clog2(INHIBIT_CYCLES + START_TIMEOUT + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, START, WAIT_FIRST, SEND,
        WAIT_ACK, WAIT_IDLE, DONE, ERROR
    } state_t;

    state_t state, state_next;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic          sync_clk, sync_dat, fall, rise;
    logic [7:0]    cmd;
    logic          parity;
    logic          dat_low;
    logic [3:0]    bit_idx;
    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] tx_cnt;
    logic          tx_active, tx_expired;
    logic          clk_drive_low, dat_drive_low;

    assign sync_clk   = clk_sync[1];
    assign sync_dat   = dat_sync[1];
    assign fall       = clk_prev & ~sync_clk;
    assign rise       = ~clk_prev & sync_clk;
    assign tx_active  = state inside {SEND, WAIT_ACK, WAIT_IDLE};
    assign tx_expired = tx_cnt == TW'(TX_TIMEOUT - 1);

    // Pin drive is decoded from state, so async reset releases both pins at once.
    assign PS2_CLK = clk_drive_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= sync_clk;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:
                if (send_command) state_next = INHIBIT;
            INHIBIT:
                // START adds the final low cycle of the inhibit window
                if (phase_cnt == PW'(INHIBIT_CYCLES - 2)) state_next = START;
            START:
                state_next = WAIT_FIRST;
            WAIT_FIRST:
                if (fall)
                    state_next = SEND;
                else if (phase_cnt == PW'(START_TIMEOUT - 1))
                    state_next = ERROR;
            SEND:
                if (tx_expired)
                    state_next = ERROR;
                else if (fall && bit_idx == 4'd10)
                    state_next = WAIT_ACK;
            WAIT_ACK:
                if (tx_expired)
                    state_next = ERROR;
                else if (rise)
                    state_next = sync_dat ? ERROR : WAIT_IDLE;
            WAIT_IDLE:
                if (tx_expired)
                    state_next = ERROR;
                else if (sync_clk && sync_dat)
                    state_next = DONE;
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy                          = 1'b1;
        command_was_sent              = 1'b0;
        error_communication_timed_out = 1'b0;
        clk_drive_low                 = 1'b0;
        dat_drive_low                 = 1'b0;
        unique case (state)
            IDLE:       busy = 1'b0;
            INHIBIT:    clk_drive_low = 1'b1;
            START: begin
                clk_drive_low = 1'b1;
                dat_drive_low = 1'b1;
            end
            WAIT_FIRST: dat_drive_low = 1'b1;
            SEND:       dat_drive_low = dat_low;
            DONE:       command_was_sent = 1'b1;
            ERROR:      error_communication_timed_out = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cmd       <= 8'h00;
            parity    <= 1'b0;
            dat_low   <= 1'b0;
            bit_idx   <= 4'd0;
            phase_cnt <= '0;
            tx_cnt    <= '0;
        end else begin
            phase_cnt <= (state_next != state) ? '0 : phase_cnt + 1'b1;
            tx_cnt    <= tx_active ? tx_cnt + 1'b1 : '0;
            if (state == IDLE && send_command) begin
                cmd    <= the_command;
                parity <= ~^the_command;
            end
            if (state == WAIT_FIRST && fall) begin
                dat_low <= ~cmd[0];
                bit_idx <= 4'd1;
            end else if (state == SEND && fall) begin
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx < 4'd8)
                    dat_low <= ~cmd[bit_idx[2:0]];
                else if (bit_idx == 4'd8)
                    dat_low <= ~parity;
                else
                    dat_low <= 1'b0;
            end
        end
    end
endmodule
